prim_ram_2p_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sits in front of a `prim_generic_ram_2p` instance and drives its two ports as the initiator. Port A performs all writes and port B all reads. A valid/ready write interface and a valid/ready read interface face the client. A 2-entry output buffer hides the RAM's 1-cycle read latency, so the controller sustains one push and one pop per cycle.

---
 rtl/prim_ram_2p_fifo_ctrl.sv | 124 ++++++++++++
 tb/tb_prim_ram_2p_fifo_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_ram_2p_fifo_ctrl.sv
// prim_ram_2p_fifo_ctrl: FIFO controller wrapped around a two-port RAM.
// Port A writes pushed data, port B prefetches the head into a 2-entry
// output buffer so the RAM's one-cycle read latency stays hidden.
module prim_ram_2p_fifo_ctrl #(
    parameter int Width  = 32,
    parameter int Depth  = 128,
    parameter int Aw     = $clog2(Depth),
    parameter int DepthW = $clog2(Depth + 3)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,

    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,

    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,

    output logic [DepthW-1:0] depth_o,
    output logic              full_o,
    output logic              empty_o,

    output logic              ram_a_req_o,
    output logic              ram_a_write_o,
    output logic [Aw-1:0]     ram_a_addr_o,
    output logic [Width-1:0]  ram_a_wdata_o,

    output logic              ram_b_req_o,
    output logic              ram_b_write_o,
    output logic [Aw-1:0]     ram_b_addr_o,
    input  logic [Width-1:0]  ram_b_rdata_i
);

    localparam logic [Aw:0] RamFull = (Aw + 1)'(Depth);

    logic [Aw:0]      wptr, rptr, ram_cnt;
    logic             inflight;
    logic [Width-1:0] obuf0, obuf1;
    logic [1:0]       obuf_cnt;

    logic             active, push, pop, fetch;
    logic [2:0]       occ_after_pop;

    logic [Width-1:0] obuf0_n, obuf1_n;
    logic [1:0]       obuf_cnt_n;

    // The wrap bit makes the pointer difference the exact RAM occupancy,
    // including the full case where the low address bits coincide.
    assign ram_cnt  = wptr - rptr;
    assign active   = rst_ni && !clr_i;

    assign wready_o = (ram_cnt != RamFull) && active;
    assign push     = wvalid_i && wready_o;

    assign rvalid_o = (obuf_cnt != 2'd0);
    assign rdata_o  = obuf0;
    assign pop      = rvalid_o && rready_i;

    // A fetch is only issued when the buffer will have room for its data
    // next cycle, counting the read already on its way back.
    assign occ_after_pop = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign fetch         = active && (ram_cnt != '0) && (occ_after_pop < 3'd2);

    assign ram_a_req_o   = push;
    assign ram_a_write_o = push;
    assign ram_a_addr_o  = push ? wptr[Aw-1:0] : '0;
    assign ram_a_wdata_o = push ? wdata_i : '0;

    assign ram_b_req_o   = fetch;
    assign ram_b_write_o = 1'b0;
    assign ram_b_addr_o  = fetch ? rptr[Aw-1:0] : '0;

    assign depth_o = DepthW'(ram_cnt) + DepthW'(inflight) + DepthW'(obuf_cnt);
    assign full_o  = !wready_o;
    assign empty_o = (depth_o == '0);

    // Output buffer update: pop shifts the head out, then returning read
    // data lands in the first free slot.
    always_comb begin
        obuf0_n    = obuf0;
        obuf1_n    = obuf1;
        obuf_cnt_n = obuf_cnt;
        if (pop) begin
            obuf0_n    = obuf1;
            obuf_cnt_n = obuf_cnt - 2'd1;
        end
        if (inflight) begin
            if (obuf_cnt_n == 2'd0) begin
                obuf0_n = ram_b_rdata_i;
            end else begin
                obuf1_n = ram_b_rdata_i;
            end
            obuf_cnt_n = obuf_cnt_n + 2'd1;
        end
    end

    // Pointers, read tracking and buffer registers; reset and flush both
    // drop everything, including data of a read still in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            wptr     <= '0;
            rptr     <= '0;
            inflight <= 1'b0;
            obuf0    <= '0;
            obuf1    <= '0;
            obuf_cnt <= 2'd0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (fetch) begin
                rptr <= rptr + 1'b1;
            end
            inflight <= fetch;
            obuf0    <= obuf0_n;
            obuf1    <= obuf1_n;
            obuf_cnt <= obuf_cnt_n;
        end
    end

endmodule

// File: tb/tb_prim_ram_2p_fifo_ctrl.sv
// tb_prim_ram_2p_fifo_ctrl: bench for the RAM-backed FIFO controller with a
// behavioural RAM and a queue-based reference model of the FIFO contents.
module tb_prim_ram_2p_fifo_ctrl;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AW = 2;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          wvalid = 1'b0;
    logic          rready = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          wready, rvalid, full, empty;
    logic [W-1:0]  rdata;
    logic [DW-1:0] depth;
    logic          ram_a_req, ram_a_write, ram_b_req, ram_b_write;
    logic [AW-1:0] ram_a_addr, ram_b_addr;
    logic [W-1:0]  ram_a_wdata, ram_b_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prim_ram_2p_fifo_ctrl #(.Width(W), .Depth(D)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata),
        .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
        .depth_o(depth), .full_o(full), .empty_o(empty),
        .ram_a_req_o(ram_a_req), .ram_a_write_o(ram_a_write),
        .ram_a_addr_o(ram_a_addr), .ram_a_wdata_o(ram_a_wdata),
        .ram_b_req_o(ram_b_req), .ram_b_write_o(ram_b_write),
        .ram_b_addr_o(ram_b_addr), .ram_b_rdata_i(ram_b_rdata)
    );

    // Behavioural two-port RAM: write on port A, registered read on port B.
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (ram_a_req && ram_a_write) mem[ram_a_addr] <= ram_a_wdata;
        if (ram_b_req) ram_b_rdata <= mem[ram_b_addr];
    end

    // Reference model: the FIFO as "stored in RAM", "being read" and
    // "visible in the output buffer", plus totals that give the addresses.
    logic [W-1:0] ram_q[$];
    logic [W-1:0] ob_q[$];
    bit           flight_v = 1'b0;
    logic [W-1:0] flight_d = '0;
    int           push_total = 0;
    int           fetch_total = 0;
    bit           mp, mpo, mf;

    function automatic bit m_wready();
        return rst_n && !clr && (ram_q.size() != D);
    endfunction

    function automatic bit m_pop();
        return (ob_q.size() != 0) && rready;
    endfunction

    function automatic bit m_fetch();
        int occ;
        occ = ob_q.size() + int'(flight_v) - int'(m_pop());
        return rst_n && !clr && (ram_q.size() != 0) && (occ < 2);
    endfunction

    function automatic int m_depth();
        return ram_q.size() + int'(flight_v) + ob_q.size();
    endfunction

    // Advance the model on each clock edge from the inputs the DUT sees.
    always @(posedge clk) begin
        mp  = wvalid && m_wready();
        mpo = m_pop();
        mf  = m_fetch();
        if (!rst_n || clr) begin
            ram_q.delete();
            ob_q.delete();
            flight_v    = 1'b0;
            push_total  = 0;
            fetch_total = 0;
        end else begin
            if (mpo) void'(ob_q.pop_front());
            if (flight_v) ob_q.push_back(flight_d);
            flight_v = mf;
            if (mf) begin
                flight_d = ram_q.pop_front();
                fetch_total++;
            end
            if (mp) begin
                ram_q.push_back(wdata);
                push_total++;
            end
        end
    end

    // Counts port A address roll-overs from the last word back to word 0.
    int           wraps = 0;
    bit           have_last = 1'b0;
    logic [AW-1:0] last_a = '0;
    always @(posedge clk) begin
        if (ram_a_req) begin
            if (have_last && last_a == AW'(D - 1) && ram_a_addr == '0) wraps++;
            last_a    = ram_a_addr;
            have_last = 1'b1;
        end
    end

    // Drive one cycle's inputs just after the falling edge, then let them settle.
    task automatic set_in(input bit wv, input logic [W-1:0] wd, input bit rr, input bit cl);
        @(negedge clk);
        wvalid = wv;
        wdata  = wd;
        rready = rr;
        clr    = cl;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b1, 8'h11, 1'b1, 1'b0);
        checks++; if (wready !== 1'b0) begin errors++; $display("[TB] FAIL reset_wready: got %0h expected 0", wready); end
        checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL reset_full: got %0h expected 1", full); end
        checks++; if (ram_a_req !== 1'b0 || ram_b_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_req: got a=%0h b=%0h expected 0", ram_a_req, ram_b_req); end
        checks++; if (rvalid !== 1'b0 || depth !== '0 || empty !== 1'b1 || rdata !== '0) begin
            errors++; $display("[TB] FAIL reset_values: got rvalid=%0h depth=%0h empty=%0h rdata=%0h expected 0/0/1/0", rvalid, depth, empty, rdata);
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        checks++; if (full !== 1'b0 || wready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release: got full=%0h wready=%0h expected 0/1", full, wready); end
    endtask

    task automatic test_basic_latency();
        int lat;
        lat = 0;
        set_in(1'b1, 8'hA5, 1'b0, 1'b0);
        checks++; if (ram_a_req !== 1'b1 || ram_a_write !== 1'b1 || ram_a_wdata !== 8'hA5) begin
            errors++; $display("[TB] FAIL basic_port_a: got req=%0h we=%0h wdata=%0h expected 1/1/a5", ram_a_req, ram_a_write, ram_a_wdata);
        end
        for (int k = 1; k <= 8; k++) begin
            set_in(1'b0, '0, 1'b0, 1'b0);
            if (rvalid) begin lat = k; break; end
        end
        checks++; if (lat != 3) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 3", lat); end
        checks++; if (rdata !== 8'hA5) begin errors++; $display("[TB] FAIL basic_rdata: got %0h expected a5", rdata); end
        set_in(1'b0, '0, 1'b1, 1'b0);
        set_in(1'b0, '0, 1'b0, 1'b0);
        checks++; if (empty !== 1'b1 || depth !== '0) begin errors++; $display("[TB] FAIL basic_empty: got empty=%0h depth=%0h expected 1/0", empty, depth); end
    endtask

    task automatic test_fill();
        int got;
        got = 0;
        for (int i = 1; i <= 6; i++) begin
            set_in(1'b1, W'(i), 1'b0, 1'b0);
            checks++; if (wready !== 1'b1) begin errors++; $display("[TB] FAIL fill_accept_%0d: got wready=%0h expected 1", i, wready); end
        end
        set_in(1'b1, 8'h07, 1'b0, 1'b0);
        checks++; if (wready !== 1'b0 || full !== 1'b1) begin errors++; $display("[TB] FAIL fill_stall: got wready=%0h full=%0h expected 0/1", wready, full); end
        checks++; if (depth !== 3'd6) begin errors++; $display("[TB] FAIL fill_depth: got %0d expected 6", depth); end
        for (int c = 0; c < 40 && got < 6; c++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            if (rvalid) begin
                got++;
                checks++; if (rdata !== W'(got)) begin errors++; $display("[TB] FAIL fill_order: got %0h expected %0h", rdata, got); end
            end
        end
        checks++; if (got != 6) begin errors++; $display("[TB] FAIL fill_pop_count: got %0d expected 6", got); end
        set_in(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Three entries are primed: an item pushed now becomes visible three
    // cycles later, so a steady one-per-cycle stream needs three in flight.
    task automatic test_back_to_back();
        logic [W-1:0] sent[$];
        logic [W-1:0] d;
        for (int i = 0; i < 3; i++) begin
            d = W'($urandom);
            set_in(1'b1, d, 1'b0, 1'b0);
            sent.push_back(d);
        end
        for (int i = 0; i < 4; i++) set_in(1'b0, '0, 1'b0, 1'b0);
        wraps = 0;
        for (int i = 0; i < 20; i++) begin
            d = W'($urandom);
            set_in(1'b1, d, 1'b1, 1'b0);
            sent.push_back(d);
            checks++; if (wready !== 1'b1 || rvalid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_bubble_%0d: got wready=%0h rvalid=%0h expected 1/1", i, wready, rvalid); end
            d = sent.pop_front();
            checks++; if (rdata !== d) begin errors++; $display("[TB] FAIL b2b_data_%0d: got %0h expected %0h", i, rdata, d); end
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        checks++; if (wraps < 4) begin errors++; $display("[TB] FAIL b2b_wraps: got %0d expected at least 4", wraps); end
        for (int c = 0; c < 20 && sent.size() != 0; c++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            if (rvalid) begin
                d = sent.pop_front();
                checks++; if (rdata !== d) begin errors++; $display("[TB] FAIL b2b_drain: got %0h expected %0h", rdata, d); end
            end
        end
        checks++; if (sent.size() != 0) begin errors++; $display("[TB] FAIL b2b_drain_count: got %0d left expected 0", sent.size()); end
    endtask

    task automatic test_backpressure();
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) set_in(1'b1, W'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            set_in(bit'($urandom_range(0, 1)), W'($urandom), pat[i % 4], 1'b0);
            checks++; if (depth !== DW'(m_depth())) begin errors++; $display("[TB] FAIL bp_depth_%0d: got %0d expected %0d", i, depth, m_depth()); end
            checks++; if (rvalid !== (ob_q.size() != 0)) begin errors++; $display("[TB] FAIL bp_rvalid_%0d: got %0h expected %0h", i, rvalid, ob_q.size() != 0); end
            if (ob_q.size() != 0) begin
                checks++; if (rdata !== ob_q[0]) begin errors++; $display("[TB] FAIL bp_rdata_%0d: got %0h expected %0h", i, rdata, ob_q[0]); end
            end
        end
        for (int c = 0; c < 30 && m_depth() != 0; c++) set_in(1'b0, '0, 1'b1, 1'b0);
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL bp_drain: got empty=%0h expected 1", empty); end
    endtask

    task automatic test_flush();
        set_in(1'b1, 8'h5A, 1'b0, 1'b0);
        set_in(1'b1, 8'h6B, 1'b0, 1'b0);
        checks++; if (ram_b_req !== 1'b1) begin errors++; $display("[TB] FAIL flush_fetch: got b_req=%0h expected 1", ram_b_req); end
        set_in(1'b1, 8'h7C, 1'b1, 1'b1);
        checks++; if (ram_a_req !== 1'b0 || ram_b_req !== 1'b0 || wready !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_no_req: got a=%0h b=%0h wready=%0h expected 0/0/0", ram_a_req, ram_b_req, wready);
        end
        set_in(1'b0, '0, 1'b1, 1'b0);
        checks++; if (depth !== '0 || rvalid !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_state: got depth=%0d rvalid=%0h empty=%0h expected 0/0/1", depth, rvalid, empty);
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL flush_stale_%0d: got rvalid=%0h rdata=%0h expected 0", i, rvalid, rdata); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        lat = 0;
        for (int i = 0; i < 3; i++) set_in(1'b1, W'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) set_in(1'b0, '0, 1'b0, 1'b0);
        checks++; if (depth !== 3'd3) begin errors++; $display("[TB] FAIL rstmid_held: got %0d expected 3", depth); end
        set_in(1'b1, 8'h55, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (wready !== 1'b0 || full !== 1'b1 || ram_a_req !== 1'b0 || ram_b_req !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_gate: got wready=%0h full=%0h a=%0h b=%0h expected 0/1/0/0", wready, full, ram_a_req, ram_b_req);
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        checks++; if (rvalid !== 1'b0 || depth !== '0 || empty !== 1'b1 || rdata !== '0) begin
            errors++; $display("[TB] FAIL rstmid_values: got rvalid=%0h depth=%0d empty=%0h rdata=%0h expected 0/0/1/0", rvalid, depth, empty, rdata);
        end
        rst_n = 1'b1;
        set_in(1'b1, 8'h3C, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            set_in(1'b0, '0, 1'b0, 1'b0);
            if (rvalid) begin lat = k; break; end
        end
        checks++; if (lat != 3 || rdata !== 8'h3C) begin errors++; $display("[TB] FAIL rstmid_after: got lat=%0d rdata=%0h expected 3/3c", lat, rdata); end
        set_in(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
            checks++; if (wready !== m_wready() || full !== !m_wready()) begin errors++; $display("[TB] FAIL rnd_wready_%0d: got %0h expected %0h", i, wready, m_wready()); end
            checks++; if (rvalid !== (ob_q.size() != 0)) begin errors++; $display("[TB] FAIL rnd_rvalid_%0d: got %0h expected %0h", i, rvalid, ob_q.size() != 0); end
            if (ob_q.size() != 0) begin
                checks++; if (rdata !== ob_q[0]) begin errors++; $display("[TB] FAIL rnd_rdata_%0d: got %0h expected %0h", i, rdata, ob_q[0]); end
            end
            checks++; if (depth !== DW'(m_depth()) || empty !== (m_depth() == 0)) begin errors++; $display("[TB] FAIL rnd_depth_%0d: got %0d expected %0d", i, depth, m_depth()); end
            checks++; if (ram_a_req !== (wvalid && m_wready()) || ram_a_write !== ram_a_req) begin errors++; $display("[TB] FAIL rnd_a_req_%0d: got %0h expected %0h", i, ram_a_req, wvalid && m_wready()); end
            if (wvalid && m_wready()) begin
                checks++; if (ram_a_addr !== AW'(push_total % D) || ram_a_wdata !== wdata) begin
                    errors++; $display("[TB] FAIL rnd_a_port_%0d: got addr=%0h wdata=%0h expected %0h/%0h", i, ram_a_addr, ram_a_wdata, push_total % D, wdata);
                end
            end
            checks++; if (ram_b_req !== m_fetch() || ram_b_write !== 1'b0) begin errors++; $display("[TB] FAIL rnd_b_req_%0d: got %0h expected %0h", i, ram_b_req, m_fetch()); end
            if (m_fetch()) begin
                checks++; if (ram_b_addr !== AW'(fetch_total % D)) begin errors++; $display("[TB] FAIL rnd_b_addr_%0d: got %0h expected %0h", i, ram_b_addr, fetch_total % D); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_fill();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
